instr_fetch_mem: RTL and testbench

//   Parametrised instruction memory for the fetch stage: synchronous-read array

---
 rtl/instr_fetch_mem_if.sv | 39 +++
 rtl/instr_fetch_mem.sv | 147 ++++++++++++++
 tb/tb_instr_fetch_mem.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_mem_if.sv
// Fetch-side bus between the PC/loader logic and the instruction store.
// Latency: n/a (wires only).
// Backpressure: mem_conflict from the master stalls fetch; ready from the slave gates fetch/load.
//
// Ports (signals):
//   pc, fetch_req, mem_conflict            fetch request side (master -> slave)
//   load_en, load_addr, load_data          loader write port  (master -> slave)
//   instr, instr_valid, fault, ready       fetch result/status (slave -> master)
interface instr_fetch_mem_if #(
    parameter int INSTR_W = 16,
    parameter int DEPTH   = 64,
    parameter int PC_W    = 16
);
    localparam int AW = $clog2(DEPTH);

    logic [PC_W-1:0]    pc;
    logic               fetch_req;
    logic               mem_conflict;
    logic               load_en;
    logic [AW-1:0]      load_addr;
    logic [INSTR_W-1:0] load_data;

    logic [INSTR_W-1:0] instr;
    logic               instr_valid;
    logic               fault;
    logic               ready;

    // Master: PC/loader side driving requests.
    modport master (
        output pc, fetch_req, mem_conflict, load_en, load_addr, load_data,
        input  instr, instr_valid, fault, ready
    );

    // Slave: the instruction memory.
    modport slave (
        input  pc, fetch_req, mem_conflict, load_en, load_addr, load_data,
        output instr, instr_valid, fault, ready
    );
endinterface

// File: rtl/instr_fetch_mem.sv
// Instruction memory for the fetch stage with loader port, self-clearing init and range fault.
// Latency: 1 cycle from accepted fetch (fetch_req & ~mem_conflict & ready) to instr/instr_valid.
// Backpressure: mem_conflict holds instr/instr_valid/fault; ready=0 during init ignores fetch and load.
//
// Ports:
//   clk          clock, all state updates on posedge
//   rst          synchronous active-high reset; restarts the init sweep
//   bus (slave)  pc/fetch_req/mem_conflict in, load_en/load_addr/load_data in,
//                instr/instr_valid/fault/ready out (all outputs registered)
module instr_fetch_mem #(
    parameter int                   INSTR_W    = 16,
    parameter int                   DEPTH      = 64,
    parameter int                   PC_W       = 16,
    parameter int                   ADDR_SHIFT = 0,
    parameter logic [INSTR_W-1:0]   NOP_WORD   = 16'h0800
) (
    input  logic                  clk,
    input  logic                  rst,
    instr_fetch_mem_if.slave      bus
);
    localparam int AW = $clog2(DEPTH);

    // Comparison width wide enough to hold both the full shifted PC and DEPTH,
    // so an out-of-range PC is never aliased into range by truncation.
    localparam int CW = ((PC_W > 31) ? PC_W : 31) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // State and registered outputs
    // ------------------------------------------------------------------
    state_t              state_q;
    logic [AW-1:0]       init_cnt_q;
    logic [INSTR_W-1:0]  instr_q;
    logic                instr_valid_q;
    logic                fault_q;
    logic                ready_q;

    logic [INSTR_W-1:0]  mem_q [DEPTH];

    // ------------------------------------------------------------------
    // Fetch index decode
    // ------------------------------------------------------------------
    logic [PC_W-1:0]     idx;
    logic [CW-1:0]       idx_ext;
    logic                in_range;
    logic [AW-1:0]       rd_idx;
    logic [INSTR_W-1:0]  rd_word;
    logic                fetch_acc;

    // Low ADDR_SHIFT bits are simply dropped; misaligned PCs are not flagged.
    assign idx      = bus.pc >> ADDR_SHIFT;
    assign idx_ext  = CW'(idx);
    assign in_range = (idx_ext < DEPTH_C);
    assign rd_idx   = idx[AW-1:0];

    // mem_q is only updated by non-blocking writes, so a same-cycle load to
    // the fetched index still returns the old word (read-before-write).
    assign rd_word  = mem_q[rd_idx];

    assign fetch_acc = (state_q == ST_RUN) && !bus.mem_conflict && bus.fetch_req;

    // ------------------------------------------------------------------
    // Memory write port: init sweep owns it during INIT, loader during RUN
    // ------------------------------------------------------------------
    logic                mem_we;
    logic [AW-1:0]       mem_waddr;
    logic [INSTR_W-1:0]  mem_wdata;

    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = init_cnt_q;
        mem_wdata = NOP_WORD;
        if (!rst) begin
            if (state_q == ST_INIT) begin
                mem_we = 1'b1;
            end else if (bus.load_en) begin
                mem_we    = 1'b1;
                mem_waddr = bus.load_addr;
                mem_wdata = bus.load_data;
            end
        end
    end

    // Array contents are not reset; the init sweep clears them instead.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    // ------------------------------------------------------------------
    // Control FSM with registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_INIT;
            init_cnt_q    <= '0;
            instr_q       <= NOP_WORD;
            instr_valid_q <= 1'b0;
            fault_q       <= 1'b0;
            ready_q       <= 1'b0;
        end else begin
            case (state_q)
                ST_INIT: begin
                    instr_valid_q <= 1'b0;
                    fault_q       <= 1'b0;
                    init_cnt_q    <= init_cnt_q + 1'b1;
                    if (init_cnt_q == LAST_IDX) begin
                        state_q <= ST_RUN;
                        ready_q <= 1'b1;
                    end
                end
                ST_RUN: begin
                    // Under conflict nothing is accepted and all fetch outputs hold.
                    if (!bus.mem_conflict) begin
                        instr_valid_q <= fetch_acc;
                        if (fetch_acc) begin
                            if (in_range) begin
                                instr_q <= rd_word;
                                fault_q <= 1'b0;
                            end else begin
                                instr_q <= NOP_WORD;
                                fault_q <= 1'b1;
                            end
                        end else begin
                            fault_q <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q <= ST_INIT;
                end
            endcase
        end
    end

    assign bus.instr       = instr_q;
    assign bus.instr_valid = instr_valid_q;
    assign bus.fault       = fault_q;
    assign bus.ready       = ready_q;
endmodule

// File: tb/tb_instr_fetch_mem.sv
module tb_instr_fetch_mem;
    localparam logic [15:0] NOP = 16'h0800;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rst2 = 1'b1;

    always #5 clk = ~clk;

    instr_fetch_mem_if #(.INSTR_W(16), .DEPTH(64), .PC_W(16)) bus ();
    instr_fetch_mem_if #(.INSTR_W(16), .DEPTH(64), .PC_W(16)) bus2 ();

    instr_fetch_mem #(.INSTR_W(16), .DEPTH(64), .PC_W(16), .ADDR_SHIFT(0), .NOP_WORD(16'h0800))
        u_dut (.clk(clk), .rst(rst), .bus(bus));

    instr_fetch_mem #(.INSTR_W(16), .DEPTH(64), .PC_W(16), .ADDR_SHIFT(2), .NOP_WORD(16'h0800))
        u_dut2 (.clk(clk), .rst(rst2), .bus(bus2));

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: memory image plus expected output state.
    logic [15:0] m_mem [64];
    logic [15:0] m_instr;
    logic        m_valid;
    logic        m_fault;
    logic        m_ready;
    int          m_init_cycles;

    typedef struct {
        logic [15:0] pc;
        logic        req;
        logic        conf;
        logic        le;
        logic [5:0]  la;
        logic [15:0] ld;
        logic [15:0] e_instr;
        logic        e_valid;
        logic        e_fault;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add_vec(input logic [15:0] pc, input logic req, input logic conf,
                           input logic le, input logic [5:0] la, input logic [15:0] ld,
                           input logic [15:0] ei, input logic ev, input logic ef);
        vec_t v;
        v.pc = pc; v.req = req; v.conf = conf; v.le = le; v.la = la; v.ld = ld;
        v.e_instr = ei; v.e_valid = ev; v.e_fault = ef;
        vecs.push_back(v);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 64; i++) m_mem[i] = NOP;
        m_instr = NOP;
        m_valid = 1'b0;
        m_fault = 1'b0;
        m_ready = 1'b0;
        m_init_cycles = 0;
    endtask

    // Drive one cycle on the main DUT, advance the model by the rules, step the clock.
    task automatic apply(input logic [15:0] pc, input logic req, input logic conf,
                         input logic le, input logic [5:0] la, input logic [15:0] ld);
        int idx;
        bus.pc = pc; bus.fetch_req = req; bus.mem_conflict = conf;
        bus.load_en = le; bus.load_addr = la; bus.load_data = ld;
        if (m_ready) begin
            if (!conf) begin
                m_valid = req;
                if (req) begin
                    idx = int'(pc);
                    if (idx < 64) begin
                        m_instr = m_mem[idx];
                        m_fault = 1'b0;
                    end else begin
                        m_instr = NOP;
                        m_fault = 1'b1;
                    end
                end else begin
                    m_fault = 1'b0;
                end
            end
            if (le) m_mem[la] = ld;
        end else begin
            m_valid = 1'b0;
            m_fault = 1'b0;
            m_init_cycles++;
            if (m_init_cycles == 64) m_ready = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic chk_model(input string tag);
        chk({tag, ".instr"}, 32'(bus.instr), 32'(m_instr));
        chk({tag, ".valid"}, 32'(bus.instr_valid), 32'(m_valid));
        chk({tag, ".fault"}, 32'(bus.fault), 32'(m_fault));
        chk({tag, ".ready"}, 32'(bus.ready), 32'(m_ready));
    endtask

    task automatic do_reset();
        bus.fetch_req = 1'b0; bus.mem_conflict = 1'b0; bus.load_en = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        model_reset();
        chk("rst.instr", 32'(bus.instr), 32'(NOP));
        chk("rst.valid", 32'(bus.instr_valid), 32'd0);
        chk("rst.fault", 32'(bus.fault), 32'd0);
        chk("rst.ready", 32'(bus.ready), 32'd0);
        rst = 1'b0;
    endtask

    // Run the init sweep while hammering fetch/load, which must be ignored.
    task automatic run_init(input string tag);
        int cnt;
        cnt = 0;
        while (!bus.ready && cnt < 200) begin
            apply(16'($urandom_range(0, 63)), 1'b1, 1'b0, 1'b1,
                  6'($urandom_range(0, 63)), 16'($urandom));
            cnt++;
            chk_model(tag);
        end
        chk({tag, ".cycles_to_ready"}, 32'(cnt), 32'd64);
    endtask

    task automatic step2(input logic [15:0] pc, input logic req,
                         input logic le, input logic [5:0] la, input logic [15:0] ld);
        bus2.pc = pc; bus2.fetch_req = req; bus2.mem_conflict = 1'b0;
        bus2.load_en = le; bus2.load_addr = la; bus2.load_data = ld;
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t v;
        int   cnt;
        logic [15:0] r_pc;

        bus.pc = '0; bus.fetch_req = 1'b0; bus.mem_conflict = 1'b0;
        bus.load_en = 1'b0; bus.load_addr = '0; bus.load_data = '0;
        bus2.pc = '0; bus2.fetch_req = 1'b0; bus2.mem_conflict = 1'b0;
        bus2.load_en = 1'b0; bus2.load_addr = '0; bus2.load_data = '0;

        // ---- Reset, init timing, all words cleared ----
        do_reset();
        run_init("init1");
        for (int i = 0; i < 64; i++) begin
            apply(16'(i), 1'b1, 1'b0, 1'b0, '0, '0);
            chk("clr.instr", 32'(bus.instr), 32'(NOP));
            chk("clr.valid", 32'(bus.instr_valid), 32'd1);
            chk("clr.fault", 32'(bus.fault), 32'd0);
        end

        // ---- Table: load/fetch, read-before-write, conflict hold, faults ----
        //       pc        req  conf le  la  ld         instr      v  f
        add_vec(16'd0,     0,   0,   1,  5,  16'h4801,  NOP,       0, 0);
        add_vec(16'd5,     1,   0,   0,  0,  16'h0000,  16'h4801,  1, 0);
        add_vec(16'd5,     1,   0,   1,  5,  16'hE82C,  16'h4801,  1, 0);
        add_vec(16'd5,     1,   0,   0,  0,  16'h0000,  16'hE82C,  1, 0);
        add_vec(16'd0,     0,   0,   1,  3,  16'h1111,  16'hE82C,  0, 0);
        add_vec(16'd3,     1,   0,   1,  4,  16'h2222,  16'h1111,  1, 0);
        add_vec(16'd4,     1,   1,   1,  6,  16'h3333,  16'h1111,  1, 0);
        add_vec(16'd4,     1,   1,   0,  0,  16'h0000,  16'h1111,  1, 0);
        add_vec(16'd4,     1,   1,   0,  0,  16'h0000,  16'h1111,  1, 0);
        add_vec(16'd4,     1,   0,   0,  0,  16'h0000,  16'h2222,  1, 0);
        add_vec(16'd6,     1,   0,   0,  0,  16'h0000,  16'h3333,  1, 0);
        add_vec(16'd64,    1,   0,   0,  0,  16'h0000,  NOP,       1, 1);
        add_vec(16'hFFFF,  1,   0,   0,  0,  16'h0000,  NOP,       1, 1);
        add_vec(16'd1,     1,   0,   0,  0,  16'h0000,  NOP,       1, 0);
        add_vec(16'd0,     0,   0,   0,  0,  16'h0000,  NOP,       0, 0);
        add_vec(16'h0100,  1,   0,   0,  0,  16'h0000,  NOP,       1, 1);
        add_vec(16'd2,     0,   1,   0,  0,  16'h0000,  NOP,       1, 1);
        add_vec(16'd2,     0,   0,   0,  0,  16'h0000,  NOP,       0, 0);
        add_vec(16'd6,     0,   1,   0,  0,  16'h0000,  NOP,       0, 0);
        add_vec(16'd6,     1,   0,   0,  0,  16'h0000,  16'h3333,  1, 0);

        foreach (vecs[k]) begin
            v = vecs[k];
            apply(v.pc, v.req, v.conf, v.le, v.la, v.ld);
            chk($sformatf("vec%0d.instr", k), 32'(bus.instr), 32'(v.e_instr));
            chk($sformatf("vec%0d.valid", k), 32'(bus.instr_valid), 32'(v.e_valid));
            chk($sformatf("vec%0d.fault", k), 32'(bus.fault), 32'(v.e_fault));
            chk($sformatf("vec%0d.ready", k), 32'(bus.ready), 32'd1);
        end

        // ---- Randomized traffic against the model ----
        for (int i = 0; i < 400; i++) begin
            r_pc = ($urandom_range(0, 9) == 0) ? 16'($urandom) : 16'($urandom_range(0, 70));
            apply(r_pc, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) == 0),
                  1'($urandom_range(0, 2) == 0), 6'($urandom_range(0, 63)), 16'($urandom));
            chk_model("rand");
        end

        // ---- Mid-run reset, loads during INIT ignored, all words cleared ----
        do_reset();
        run_init("init2");
        for (int i = 0; i < 64; i++) begin
            apply(16'(i), 1'b1, 1'b0, 1'b0, '0, '0);
            chk("reclr.instr", 32'(bus.instr), 32'(NOP));
            chk("reclr.valid", 32'(bus.instr_valid), 32'd1);
        end

        // ---- ADDR_SHIFT=2 instance ----
        step2('0, 1'b0, 1'b0, '0, '0);
        chk("s2.rst.ready", 32'(bus2.ready), 32'd0);
        rst2 = 1'b0;
        cnt = 0;
        while (!bus2.ready && cnt < 200) begin
            step2('0, 1'b0, 1'b0, '0, '0);
            cnt++;
        end
        chk("s2.cycles_to_ready", 32'(cnt), 32'd64);
        for (int i = 0; i < 4; i++) step2('0, 1'b0, 1'b1, 6'(i), 16'hA000 + 16'(i));
        for (int i = 0; i < 4; i++) begin
            step2(16'(4 * i), 1'b1, 1'b0, '0, '0);
            chk($sformatf("s2.pc%0d", 4 * i), 32'(bus2.instr), 32'(16'hA000 + 16'(i)));
            chk("s2.valid", 32'(bus2.instr_valid), 32'd1);
        end
        step2(16'd6, 1'b1, 1'b0, '0, '0);
        chk("s2.pc6", 32'(bus2.instr), 32'h0000A001);
        step2(16'd255, 1'b1, 1'b0, '0, '0);
        chk("s2.pc255.instr", 32'(bus2.instr), 32'(NOP));
        chk("s2.pc255.fault", 32'(bus2.fault), 32'd0);
        step2(16'd256, 1'b1, 1'b0, '0, '0);
        chk("s2.pc256.fault", 32'(bus2.fault), 32'd1);
        chk("s2.pc256.instr", 32'(bus2.instr), 32'(NOP));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
